// File: rtl/dft_uart_pkg.sv
// Shared definitions for the DFT UART word paths: rx FSM encoding, default
// register addresses and status register bit positions.
package dft_uart_pkg;

    typedef enum logic [4:0] {
        WAIT_B3 = 5'b00001,
        WAIT_B2 = 5'b00010,
        WAIT_B1 = 5'b00100,
        WAIT_B0 = 5'b01000
    } rx_state_t;

    localparam logic [31:0] DATA_ADDR_DEFAULT = 32'h0000_0003;
    localparam logic [31:0] STAT_ADDR_DEFAULT = 32'h0000_0004;

    localparam int STAT_VALID_BIT   = 0;
    localparam int STAT_OVERRUN_BIT = 1;

endpackage

// File: rtl/dft_uart_rx_timer.sv
// Inter-byte watchdog counter: counts while enabled, expires on its last count.
module dft_uart_rx_timer #(
    parameter int          WIDTH = 28,
    parameter logic [27:0] LIMIT = 28'd50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == WIDTH'(LIMIT - 28'd1));

endmodule

// File: rtl/dft_uart_rx_word.sv
// Host-to-core DFT receive path: packs four UART bytes MSB-first into a word
// exposed via memory-mapped data/status. Optional macro: DFT_UART_RX_TIMEOUT_EN.
module dft_uart_rx_word
    import dft_uart_pkg::*;
#(
    parameter int                   BIT_WIDTH      = 32,
    parameter logic [BIT_WIDTH-1:0] DATA_ADDR      = DATA_ADDR_DEFAULT,
    parameter logic [BIT_WIDTH-1:0] STAT_ADDR      = STAT_ADDR_DEFAULT,
    parameter logic [27:0]          TIMEOUT_CYCLES = 28'd50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           uart_dat_o,
    input  logic                 uart_rx_ready,
    input  logic [BIT_WIDTH-1:0] Address,
    input  logic                 MemRead,
    output logic [BIT_WIDTH-1:0] rd_data,
    output logic                 rd_hit,
    output logic                 word_valid,
    output logic                 overrun
);

    rx_state_t            state;
    logic [31:0]          shift_reg;
    logic [BIT_WIDTH-1:0] word_reg;
    logic                 data_rd;
    logic                 stat_rd;
    logic                 complete;
    logic                 timeout;

    assign data_rd  = MemRead && (Address == DATA_ADDR);
    assign stat_rd  = MemRead && (Address == STAT_ADDR);
    assign rd_hit   = data_rd || stat_rd;
    assign complete = uart_rx_ready && (state == WAIT_B0);

`ifdef DFT_UART_RX_TIMEOUT_EN
    dft_uart_rx_timer #(
        .WIDTH (28),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst),
        .clear  (uart_rx_ready || (state == WAIT_B3)),
        .enable (state != WAIT_B3),
        .expire (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_B3;
            shift_reg <= '0;
        end else if (uart_rx_ready) begin
            // A strobe always wins over a coincident timeout.
            unique case (state)
                WAIT_B3: begin shift_reg[31:24] <= uart_dat_o; state <= WAIT_B2; end
                WAIT_B2: begin shift_reg[23:16] <= uart_dat_o; state <= WAIT_B1; end
                WAIT_B1: begin shift_reg[15:8]  <= uart_dat_o; state <= WAIT_B0; end
                WAIT_B0: begin shift_reg[7:0]   <= uart_dat_o; state <= WAIT_B3; end
                default: state <= WAIT_B3;
            endcase
        end else if (timeout) begin
            state <= WAIT_B3;
        end
    end

    // Flag sets take priority over read-side clears in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_reg   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (complete && (!word_valid || data_rd)) begin
                word_reg   <= BIT_WIDTH'({shift_reg[31:8], uart_dat_o});
                word_valid <= 1'b1;
            end else if (data_rd) begin
                word_valid <= 1'b0;
            end

            if (complete && word_valid && !data_rd) begin
                overrun <= 1'b1;
            end else if (stat_rd) begin
                overrun <= 1'b0;
            end
        end
    end

    // NOTE: rd_data gets a default before any branch so no latch is inferred.
    always_comb begin
        rd_data = '0;
        if (data_rd) begin
            rd_data = word_reg;
        end else if (stat_rd) begin
            rd_data[STAT_VALID_BIT]   = word_valid;
            rd_data[STAT_OVERRUN_BIT] = overrun;
        end
    end

endmodule

// File: doc/dft_uart_rx_word.md
# dft_uart_rx_word

Design-for-test receive path for the MIPS multi-cycle processor. It collects bytes delivered by the UART receiver core, packs four of them MSB-first into a 32-bit word, and presents that word to the processor through memory-mapped data and status locations. It is the host-to-core counterpart of the DFT UART transmit path, which sends a word out as bytes [31:24], [23:16], [15:8], [7:0] in that order.

## Interface
- BIT_WIDTH, 32: processor data/address width; must be 32.
- DATA_ADDR, 32'h00000003: word address of the received-data register.
- STAT_ADDR, 32'h00000004: word address of the status register.
- TIMEOUT_CYCLES, 28'd50000000: maximum clk cycles allowed between bytes of one word (1 s at 50 MHz).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- uart_dat_o  in  8  byte from the UART receiver core; valid only while uart_rx_ready=1.
- uart_rx_ready  in  1  one-cycle strobe per received byte.
- Address  in  BIT_WIDTH  processor memory address.
- MemRead  in  1  processor read enable.
- rd_data  out  BIT_WIDTH  read data, combinational from Address/MemRead.
- rd_hit  out  1  MemRead=1 and Address equals DATA_ADDR or STAT_ADDR.
- word_valid  out  1  a complete word is held and has not yet been read.
- overrun  out  1  sticky flag: a word was completed while word_valid=1.

## Operation
- FSM states: WAIT_B3, WAIT_B2, WAIT_B1, WAIT_B0. Reset state is WAIT_B3.
- In WAIT_Bn, a uart_rx_ready strobe writes uart_dat_o into shift_reg[8n+7:8n] and advances the FSM (B3→B2→B1→B0). A strobe in WAIT_B0 completes the word and returns the FSM to WAIT_B3.
- On completion with word_valid=0 (or with word_valid being cleared by a data read in the same cycle), word_reg is loaded with {shift_reg[31:8], uart_dat_o} and word_valid is set to 1.
- On completion with word_valid=1 and no data read in that cycle, the new word is dropped, word_reg is unchanged, and overrun is set to 1.
- rd_data: at DATA_ADDR it returns word_reg. At STAT_ADDR it returns {30'b0, overrun, word_valid}. Otherwise it returns 0. rd_data is 0 whenever MemRead=0.
- Read side effects take effect at the clock edge:
  - A DATA_ADDR read clears word_valid.
  - A STAT_ADDR read clears overrun.
  - If a set and a clear of the same flag occur in the same cycle, the set wins.
- Reset values: the FSM is WAIT_B3; shift_reg, word_reg, word_valid, overrun and the timer are all 0. rd_data and rd_hit are combinational and read 0 while MemRead=0.
- A reset asserted mid-word discards any partial bytes. Bytes strobed during reset are ignored.

## Timing
- A byte strobe sampled at edge k updates shift_reg and the FSM at edge k.
- The fourth strobe, at edge k, makes word_valid=1 and updates word_reg visibly after edge k, one cycle of latency.
- A read issued in the same cycle as completion returns the old word_reg; the new word is visible from the next cycle.
- uart_rx_ready strobes may arrive on consecutive cycles; each one is accepted, with no backpressure.
- The timer reset, the timeout and the abort rules are defined under Configuration.

## Configuration
- DFT_UART_RX_TIMEOUT_EN defined:
  - The inter-byte timer clears on every strobe and on entry to WAIT_B3, and counts while the FSM is not in WAIT_B3.
  - When the timer reaches TIMEOUT_CYCLES-1 with no strobe, the FSM returns to WAIT_B3 at the next edge and the partial word is discarded.
  - word_reg, word_valid and overrun are untouched by a timeout.
  - A strobe arriving in the same cycle as the timeout is accepted and the timeout is ignored.
- Not defined: there is no timer and no abort. A partial word waits indefinitely, and the timer logic is absent from the netlist.

## Structure
- Shared package dft_uart_pkg holds:
  - the rx FSM state enum (5-bit encoding, matching the tx FSM style),
  - DATA_ADDR and STAT_ADDR default constants,
  - the status bit positions (bit0 word_valid, bit1 overrun).
- One sub-module, dft_uart_rx_timer: a 28-bit inter-byte counter with clear, enable and an expire output. It is instantiated only under DFT_UART_RX_TIMEOUT_EN.

## Test plan
- Reset, then strobe bytes F1, E2, D3, C4 on consecutive cycles. Required: word_valid=1 one cycle after the C4 strobe. A DATA_ADDR read returns 32'hF1E2D3C4, and word_valid=0 after that edge.
- Word A is received and not read, then word B = 11223344 is received. Required: a DATA_ADDR read still returns A, STAT_ADDR reads 32'h3, and after the status read overrun=0.
- Word completes in the same cycle as a DATA_ADDR read of the previous word. Required: the read returns the old word, word_valid stays 1, overrun stays 0, and the next read returns the new word.
- Two bytes AA, BB are strobed, then rst is pulsed low mid-word, then 4 bytes 01, 02, 03, 04 are sent. Required: the word reads 32'h01020304 and no overrun.
- With DFT_UART_RX_TIMEOUT_EN and TIMEOUT_CYCLES=16, strobe AA, wait 20 cycles, then send 01, 02, 03, 04. Required: the word reads 32'h01020304. Without the macro, the word reads 32'hAA010203, leaving 04 as the first byte of the next word.
- MemRead=1 with Address=32'h00000005. Required: rd_hit=0, rd_data=0, and no flag changes.
